// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;

    localparam int unsigned PCW_DEF  = 10;
    localparam int unsigned OFFW_DEF = 8;
    localparam int unsigned CNTW     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decoder/flag inputs and sequencing outputs of the fetch sequencer.
// Optional build macro: CYCLE_COUNT_EN adds CycleCount and InstrCount.
interface fetch_sequencer_if #(
    parameter int unsigned PCW  = fetch_pkg::PCW_DEF,
    parameter int unsigned OFFW = fetch_pkg::OFFW_DEF
);
    logic            Start;
    logic            Stall;
    logic            Halt;
    logic            AbsBranch;
    logic            RelBranch;
    logic            BranchFlag;
    logic            BranchInvert;
    logic            ZeroFlag;
    logic            NegFlag;
    logic [PCW-1:0]  Target;
    logic [OFFW-1:0] RelOffset;
    logic [PCW-1:0]  PC;
    logic            InstrValid;
    logic            BranchTaken;
    logic            Running;
    logic            Done;
`ifdef CYCLE_COUNT_EN
    logic [31:0]     CycleCount;
    logic [31:0]     InstrCount;
`endif

    modport master (
        output Start, Stall, Halt, AbsBranch, RelBranch, BranchFlag, BranchInvert,
               ZeroFlag, NegFlag, Target, RelOffset,
`ifdef CYCLE_COUNT_EN
        input  CycleCount, InstrCount,
`endif
        input  PC, InstrValid, BranchTaken, Running, Done
    );

    modport slave (
        input  Start, Stall, Halt, AbsBranch, RelBranch, BranchFlag, BranchInvert,
               ZeroFlag, NegFlag, Target, RelOffset,
`ifdef CYCLE_COUNT_EN
        output CycleCount, InstrCount,
`endif
        output PC, InstrValid, BranchTaken, Running, Done
    );

endinterface

// File: rtl/branch_resolve.sv
// Combinational branch decision and next-PC selection.
module branch_resolve #(
    parameter int unsigned PCW  = fetch_pkg::PCW_DEF,
    parameter int unsigned OFFW = fetch_pkg::OFFW_DEF
) (
    input  logic [PCW-1:0]  pc,
    input  logic            abs_branch,
    input  logic            rel_branch,
    input  logic            branch_flag,
    input  logic            branch_invert,
    input  logic            zero_flag,
    input  logic            neg_flag,
    input  logic [PCW-1:0]  target,
    input  logic [OFFW-1:0] rel_offset,
    output logic            taken_c,
    output logic [PCW-1:0]  next_pc_c
);

    logic           cond_c;
    logic [PCW-1:0] offset_ext_c;

    // Flag select/invert; offset is sign-extended so the add wraps modulo 2^PCW.
    assign cond_c       = (branch_flag ? neg_flag : zero_flag) ^ branch_invert;
    assign taken_c      = (abs_branch | rel_branch) & cond_c;
    assign offset_ext_c = PCW'($signed(rel_offset));

    // Absolute wins over relative; fall through to sequential increment.
    always_comb begin
        next_pc_c = pc + PCW'(1);
        if (taken_c) begin
            if (abs_branch) begin
                next_pc_c = target;
            end else begin
                next_pc_c = pc + offset_ext_c;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run/halt sequencing for the core.
// Optional build macro: CYCLE_COUNT_EN adds saturating cycle/instruction counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned PCW        = PCW_DEF,
    parameter int unsigned OFFW       = OFFW_DEF,
    parameter int unsigned START_ADDR = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    fetch_sequencer_if.slave bus
);

    seq_state_t     state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           taken_q, taken_d;
    logic           taken_c;
    logic [PCW-1:0] branch_pc_c;
    logic           start_ok_c;

    branch_resolve #(.PCW(PCW), .OFFW(OFFW)) u_branch (
        .pc            (pc_q),
        .abs_branch    (bus.AbsBranch),
        .rel_branch    (bus.RelBranch),
        .branch_flag   (bus.BranchFlag),
        .branch_invert (bus.BranchInvert),
        .zero_flag     (bus.ZeroFlag),
        .neg_flag      (bus.NegFlag),
        .target        (bus.Target),
        .rel_offset    (bus.RelOffset),
        .taken_c       (taken_c),
        .next_pc_c     (branch_pc_c)
    );

    // Start is honoured only outside RUN.
    assign start_ok_c = bus.Start && (state_q != RUN);

    // State, PC and branch-taken registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    // Next-state and next-PC; stall freezes everything, halt beats any branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = PCW'(START_ADDR);
                    taken_d = 1'b0;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    if (bus.Halt) begin
                        state_d = DONE;
                        taken_d = 1'b0;
                    end else begin
                        pc_d    = branch_pc_c;
                        taken_d = taken_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                taken_d = 1'b0;
            end
        endcase
    end

    assign bus.PC          = pc_q;
    assign bus.BranchTaken = taken_q;
    assign bus.Running     = (state_q == RUN);
    assign bus.Done        = (state_q == DONE);
    assign bus.InstrValid  = (state_q == RUN) && !bus.Stall;

`ifdef CYCLE_COUNT_EN
    logic [CNTW-1:0] cycle_cnt_q;
    logic [CNTW-1:0] instr_cnt_q;

    // Saturating counters, cleared by reset or an accepted Start, frozen outside RUN.
    always_ff @(posedge Clk) begin
        if (Reset || start_ok_c) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (state_q == RUN) begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + CNTW'(1);
            end
            if (!bus.Stall && (instr_cnt_q != '1)) begin
                instr_cnt_q <= instr_cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.CycleCount = cycle_cnt_q;
    assign bus.InstrCount = instr_cnt_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok_c;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int unsigned PCW  = 10;
    localparam int unsigned OFFW = 8;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_sequencer_if #(.PCW(PCW), .OFFW(OFFW)) bus ();

    fetch_sequencer #(.PCW(PCW), .OFFW(OFFW), .START_ADDR(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.Start = 0; bus.Stall = 0; bus.Halt = 0;
        bus.AbsBranch = 0; bus.RelBranch = 0; bus.BranchFlag = 0; bus.BranchInvert = 0;
        bus.ZeroFlag = 0; bus.NegFlag = 0; bus.Target = '0; bus.RelOffset = '0;
    endtask

    // Taken absolute branch (Z=0 inverted) to position the PC.
    task automatic goto_pc(input logic [PCW-1:0] addr);
        clear_ctl();
        bus.AbsBranch = 1; bus.BranchInvert = 1; bus.Target = addr;
        step();
        clear_ctl();
    endtask

    task automatic test_reset();
        clear_ctl();
        Reset = 1;
        step(); step();
        if (bus.PC !== 10'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", bus.PC); end n_cmp++;
        if (bus.Running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", bus.Running); end n_cmp++;
        if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.Done); end n_cmp++;
        if (bus.BranchTaken !== 1'b0) begin n_bad++; $display("FAIL reset_bt: got %b want 0", bus.BranchTaken); end n_cmp++;
        if (bus.InstrValid !== 1'b0) begin n_bad++; $display("FAIL reset_iv: got %b want 0", bus.InstrValid); end n_cmp++;
        Reset = 0;
        step();
        if (bus.Running !== 1'b0) begin n_bad++; $display("FAIL idle_no_start: got %b want 0", bus.Running); end n_cmp++;
    endtask

    task automatic test_sequential();
        bus.Start = 1;
        step();
        bus.Start = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.PC !== PCW'(i)) begin n_bad++; $display("FAIL seq_pc%0d: got %0d want %0d", i, bus.PC, i); end n_cmp++;
            if (bus.InstrValid !== 1'b1) begin n_bad++; $display("FAIL seq_iv%0d: got %b want 1", i, bus.InstrValid); end n_cmp++;
            if (bus.Running !== 1'b1) begin n_bad++; $display("FAIL seq_run%0d: got %b want 1", i, bus.Running); end n_cmp++;
            step();
        end
    endtask

    task automatic test_rel_branch();
        goto_pc(10'd20);
        bus.RelBranch = 1; bus.ZeroFlag = 1; bus.RelOffset = 8'hFB;
        step();
        if (bus.PC !== 10'd15) begin n_bad++; $display("FAIL rel_taken_pc: got %0d want 15", bus.PC); end n_cmp++;
        if (bus.BranchTaken !== 1'b1) begin n_bad++; $display("FAIL rel_taken_bt: got %b want 1", bus.BranchTaken); end n_cmp++;
        goto_pc(10'd20);
        bus.RelBranch = 1; bus.ZeroFlag = 0; bus.RelOffset = 8'hFB;
        step();
        if (bus.PC !== 10'd21) begin n_bad++; $display("FAIL rel_not_pc: got %0d want 21", bus.PC); end n_cmp++;
        if (bus.BranchTaken !== 1'b0) begin n_bad++; $display("FAIL rel_not_bt: got %b want 0", bus.BranchTaken); end n_cmp++;
        clear_ctl();
    endtask

    task automatic test_abs_branch();
        goto_pc(10'd7);
        bus.AbsBranch = 1; bus.BranchFlag = 1; bus.BranchInvert = 1; bus.NegFlag = 0; bus.Target = 10'd300;
        step();
        if (bus.PC !== 10'd300) begin n_bad++; $display("FAIL abs_taken_pc: got %0d want 300", bus.PC); end n_cmp++;
        if (bus.BranchTaken !== 1'b1) begin n_bad++; $display("FAIL abs_taken_bt: got %b want 1", bus.BranchTaken); end n_cmp++;
        goto_pc(10'd7);
        bus.AbsBranch = 1; bus.BranchFlag = 1; bus.BranchInvert = 1; bus.NegFlag = 1; bus.Target = 10'd300;
        step();
        if (bus.PC !== 10'd8) begin n_bad++; $display("FAIL abs_not_pc: got %0d want 8", bus.PC); end n_cmp++;
        if (bus.BranchTaken !== 1'b0) begin n_bad++; $display("FAIL abs_not_bt: got %b want 0", bus.BranchTaken); end n_cmp++;
        goto_pc(10'd2);
        bus.AbsBranch = 1; bus.RelBranch = 1; bus.BranchInvert = 1; bus.Target = 10'd40; bus.RelOffset = 8'd5;
        step();
        if (bus.PC !== 10'd40) begin n_bad++; $display("FAIL abs_over_rel: got %0d want 40", bus.PC); end n_cmp++;
        clear_ctl();
    endtask

    task automatic test_wrap();
        goto_pc(10'd1023);
        step();
        if (bus.PC !== 10'd0) begin n_bad++; $display("FAIL wrap_inc: got %0d want 0", bus.PC); end n_cmp++;
        goto_pc(10'd2);
        bus.RelBranch = 1; bus.BranchInvert = 1; bus.RelOffset = 8'h80;
        step();
        if (bus.PC !== 10'd898) begin n_bad++; $display("FAIL wrap_rel: got %0d want 898", bus.PC); end n_cmp++;
        clear_ctl();
    endtask

    task automatic test_stall();
        goto_pc(10'd8);
        step();
        bus.Stall = 1; bus.AbsBranch = 1; bus.BranchInvert = 1; bus.Target = 10'd500;
        #1;
        if (bus.InstrValid !== 1'b0) begin n_bad++; $display("FAIL stall_iv_comb: got %b want 0", bus.InstrValid); end n_cmp++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.PC !== 10'd9) begin n_bad++; $display("FAIL stall_pc%0d: got %0d want 9", i, bus.PC); end n_cmp++;
            if (bus.InstrValid !== 1'b0) begin n_bad++; $display("FAIL stall_iv%0d: got %b want 0", i, bus.InstrValid); end n_cmp++;
            if (bus.BranchTaken !== 1'b0) begin n_bad++; $display("FAIL stall_bt%0d: got %b want 0", i, bus.BranchTaken); end n_cmp++;
        end
        bus.Stall = 0;
        #1;
        if (bus.InstrValid !== 1'b1) begin n_bad++; $display("FAIL unstall_iv: got %b want 1", bus.InstrValid); end n_cmp++;
        step();
        if (bus.PC !== 10'd500) begin n_bad++; $display("FAIL unstall_pc: got %0d want 500", bus.PC); end n_cmp++;
        if (bus.BranchTaken !== 1'b1) begin n_bad++; $display("FAIL unstall_bt: got %b want 1", bus.BranchTaken); end n_cmp++;
        clear_ctl();
    endtask

    task automatic test_halt();
        goto_pc(10'd11);
        step();
        bus.Halt = 1; bus.AbsBranch = 1; bus.BranchInvert = 1; bus.Target = 10'd100;
        step();
        clear_ctl();
        #1;
        if (bus.Done !== 1'b1) begin n_bad++; $display("FAIL halt_done: got %b want 1", bus.Done); end n_cmp++;
        if (bus.Running !== 1'b0) begin n_bad++; $display("FAIL halt_running: got %b want 0", bus.Running); end n_cmp++;
        if (bus.PC !== 10'd12) begin n_bad++; $display("FAIL halt_pc: got %0d want 12", bus.PC); end n_cmp++;
        if (bus.InstrValid !== 1'b0) begin n_bad++; $display("FAIL halt_iv: got %b want 0", bus.InstrValid); end n_cmp++;
        step();
        if (bus.Done !== 1'b1) begin n_bad++; $display("FAIL done_held: got %b want 1", bus.Done); end n_cmp++;
        if (bus.PC !== 10'd12) begin n_bad++; $display("FAIL done_pc_held: got %0d want 12", bus.PC); end n_cmp++;
    endtask

    task automatic test_restart();
        bus.Start = 1;
        step();
        bus.Start = 0;
        if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", bus.Done); end n_cmp++;
        if (bus.Running !== 1'b1) begin n_bad++; $display("FAIL restart_running: got %b want 1", bus.Running); end n_cmp++;
        if (bus.PC !== 10'd0) begin n_bad++; $display("FAIL restart_pc: got %0d want 0", bus.PC); end n_cmp++;
`ifdef CYCLE_COUNT_EN
        if (bus.CycleCount !== 32'd0) begin n_bad++; $display("FAIL restart_cyc: got %0d want 0", bus.CycleCount); end n_cmp++;
        if (bus.InstrCount !== 32'd0) begin n_bad++; $display("FAIL restart_ins: got %0d want 0", bus.InstrCount); end n_cmp++;
`endif
        bus.Stall = 1;
        step();
        bus.Stall = 0;
        step();
        if (bus.PC !== 10'd1) begin n_bad++; $display("FAIL restart_pc1: got %0d want 1", bus.PC); end n_cmp++;
        bus.Start = 1;
        step();
        bus.Start = 0;
        if (bus.PC !== 10'd2) begin n_bad++; $display("FAIL start_in_run: got %0d want 2", bus.PC); end n_cmp++;
`ifdef CYCLE_COUNT_EN
        if (bus.CycleCount !== 32'd3) begin n_bad++; $display("FAIL cyc_count: got %0d want 3", bus.CycleCount); end n_cmp++;
        if (bus.InstrCount !== 32'd2) begin n_bad++; $display("FAIL ins_count: got %0d want 2", bus.InstrCount); end n_cmp++;
`endif
    endtask

    task automatic test_reset_mid_run();
        goto_pc(10'd33);
        Reset = 1;
        step();
        Reset = 0;
        if (bus.PC !== 10'd0) begin n_bad++; $display("FAIL midrst_pc: got %0d want 0", bus.PC); end n_cmp++;
        if (bus.Running !== 1'b0) begin n_bad++; $display("FAIL midrst_running: got %b want 0", bus.Running); end n_cmp++;
        if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", bus.Done); end n_cmp++;
        if (bus.BranchTaken !== 1'b0) begin n_bad++; $display("FAIL midrst_bt: got %b want 0", bus.BranchTaken); end n_cmp++;
`ifdef CYCLE_COUNT_EN
        if (bus.CycleCount !== 32'd0) begin n_bad++; $display("FAIL midrst_cyc: got %0d want 0", bus.CycleCount); end n_cmp++;
`endif
    endtask

    initial begin
        Reset = 1;
        clear_ctl();
        test_reset();
        test_sequential();
        test_rel_branch();
        test_abs_branch();
        test_wrap();
        test_stall();
        test_halt();
        test_restart();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
